// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 16;
  localparam int MAX_BURST_DEF = 4;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LVL_W  = lvl_width(DEPTH)
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rd_pop;
  logic [N_REQ-1:0]        gnt;
  logic                    write_en;
  logic [DATA_W-1:0]       wr_data;
  logic [LVL_W-1:0]        level;
  logic                    full;

  modport master (
    output req, req_data, rd_pop,
    input  gnt, write_en, wr_data, level, full
  );

  modport slave (
    input  req, req_data, rd_pop,
    output gnt, write_en, wr_data, level, full
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        win_oh_o[idx]  = 1'b1;
        win_idx_o      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; tracks occupancy
// from its own writes and the read-side pop strobe so the FIFO never overflows.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int LVL_W     = lvl_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_write_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              write_en_q, write_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [N_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              room;
  logic              beat;
  logic              pop_ok;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (bus.req),
    .last_i    (last_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // Beat decision uses the registered level: a same-cycle pop at DEPTH
  // does not open room until the following cycle.
  always_comb begin
    room   = (level_q < DEPTH_L);
    beat   = (state_q == BURST) && bus.req[cur_q] && room;
    pop_ok = bus.rd_pop && (level_q != '0);

    state_d    = state_q;
    gnt_d      = gnt_q;
    cur_d      = cur_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    write_en_d = beat;
    wr_data_d  = wr_data_q;
    level_d    = level_q;

    if (beat) begin
      wr_data_d = bus.req_data[int'(cur_q)*DATA_W +: DATA_W];
    end

    if (beat && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!beat && pop_ok) begin
      level_d = level_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if ((|bus.req) && room) begin
          cur_d      = win_idx;
          gnt_d      = win_oh;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!bus.req[cur_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = cur_q;
        end else if (room) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = cur_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      cur_q      <= '0;
      last_q     <= LAST_RST;
      beat_cnt_q <= '0;
      level_q    <= '0;
      write_en_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      level_q    <= level_d;
      write_en_q <= write_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.write_en = write_en_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.level    = level_q;
  assign bus.full     = (level_q == DEPTH_L);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a simple producer model.
module tb_fifo_write_arbiter;

  logic clk;
  logic reset;

  fifo_write_arbiter_if bus ();

  fifo_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  int          rem [4];
  logic [7:0]  nxt [4];
  logic [3:0]  gq  [$];
  logic        weq [$];
  logic [7:0]  wq  [$];

  logic [7:0] exp_rr [16] = '{8'h00, 8'h01, 8'h02, 8'h03,
                              8'h40, 8'h41, 8'h42, 8'h43,
                              8'h80, 8'h81, 8'h82, 8'h83,
                              8'h04, 8'h05, 8'h06, 8'h07};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      bus.req[i]            = (rem[i] != 0);
      bus.req_data[i*8 +: 8] = nxt[i];
    end
  endtask

  // One clock: producers advance on words consumed at this edge.
  task automatic step(input logic pop);
    logic [3:0] cons;
    bus.rd_pop = pop;
    cons = bus.gnt & bus.req & {4{~bus.full}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (cons[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    end
    gq.push_back(bus.gnt);
    weq.push_back(bus.write_en);
    if (bus.write_en) wq.push_back(bus.wr_data);
    bus.rd_pop = 1'b0;
    drive_req();
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    bus.rd_pop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      nxt[i] = '0;
    end
    drive_req();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    gq.delete();
    weq.delete();
    wq.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.rd_pop   = 1'b0;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_we", 32'(bus.write_en), 32'h0);
    check("rst_wdata", 32'(bus.wr_data), 32'h0);
    check("rst_level", 32'(bus.level), 32'h0);
    check("rst_full", 32'(bus.full), 32'h0);

    // Single producer, 6 words, bursts of 4 then 2
    rem[0] = 6;
    nxt[0] = 8'h10;
    drive_req();
    repeat (10) step(1'b0);
    check("sp_gnt_first", 32'(gq[0]), 32'h1);
    check("sp_gnt_gap", 32'(gq[4]), 32'h0);
    check("sp_we_gap", 32'(weq[5]), 32'h0);
    check("sp_regrant", 32'(gq[5]), 32'h1);
    check("sp_gnt_end", 32'(gq[8]), 32'h0);
    check("sp_nwrites", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) check($sformatf("sp_data%0d", i), 32'(wq[i]), 32'(8'h10 + i));
    end
    check("sp_level", 32'(bus.level), 32'd6);

    // Round-robin among producers 0,1,2 with continuous draining
    do_reset();
    rem[0] = 1000; nxt[0] = 8'h00;
    rem[1] = 1000; nxt[1] = 8'h40;
    rem[2] = 1000; nxt[2] = 8'h80;
    drive_req();
    repeat (20) step(1'b1);
    check("rr_g0", 32'(gq[0]), 32'h1);
    check("rr_g1", 32'(gq[5]), 32'h2);
    check("rr_g2", 32'(gq[10]), 32'h4);
    check("rr_g3", 32'(gq[15]), 32'h1);
    check("rr_gap1", 32'(gq[4]), 32'h0);
    check("rr_gap2", 32'(gq[9]), 32'h0);
    check("rr_nwrites", 32'(wq.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wq.size()) check($sformatf("rr_data%0d", i), 32'(wq[i]), 32'(exp_rr[i]));
    end

    // Full stall mid-burst, then release by one pop
    do_reset();
    rem[0] = 2;
    nxt[0] = 8'h20;
    drive_req();
    repeat (4) step(1'b0);
    check("fs_pre_level", 32'(bus.level), 32'd2);
    rem[0] = 100;
    drive_req();
    repeat (25) step(1'b0);
    check("fs_level", 32'(bus.level), 32'd16);
    check("fs_full", 32'(bus.full), 32'h1);
    check("fs_gnt_held", 32'(bus.gnt), 32'h1);
    check("fs_nwrites", 32'(wq.size()), 32'd16);
    check("fs_last_data", 32'(wq[wq.size()-1]), 32'h2F);
    step(1'b1);
    check("fs_pop_level", 32'(bus.level), 32'd15);
    check("fs_pop_we", 32'(bus.write_en), 32'h0);
    step(1'b0);
    check("fs_resume_we", 32'(bus.write_en), 32'h1);
    check("fs_resume_data", 32'(bus.wr_data), 32'h30);
    check("fs_resume_level", 32'(bus.level), 32'd16);
    step(1'b0);
    check("fs_one_beat", 32'(bus.write_en), 32'h0);

    // Simultaneous beat and pop at level 8
    do_reset();
    rem[0] = 8;
    nxt[0] = 8'h50;
    drive_req();
    repeat (10) step(1'b0);
    check("bp_pre_level", 32'(bus.level), 32'd8);
    rem[0] = 1;
    drive_req();
    step(1'b0);
    step(1'b1);
    check("bp_level", 32'(bus.level), 32'd8);
    check("bp_we", 32'(bus.write_en), 32'h1);
    check("bp_data", 32'(bus.wr_data), 32'h58);

    // Pop while empty
    do_reset();
    step(1'b1);
    step(1'b1);
    check("pe_level", 32'(bus.level), 32'd0);
    check("pe_we", 32'(bus.write_en), 32'h0);

    // Reset during the second beat of a burst
    do_reset();
    rem[0] = 100;
    nxt[0] = 8'h60;
    drive_req();
    step(1'b0);
    step(1'b0);
    check("rm_pre_we", 32'(bus.write_en), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rm_gnt", 32'(bus.gnt), 32'h0);
    check("rm_we", 32'(bus.write_en), 32'h0);
    check("rm_level", 32'(bus.level), 32'h0);
    rem[0] = 0;
    rem[1] = 100; nxt[1] = 8'h70;
    rem[2] = 100; nxt[2] = 8'h90;
    drive_req();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rm_first_gnt", 32'(bus.gnt), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of the 8-bit FIFO datapath between several producers. Arbitrates round-robin, grants bursts of up to MAX_BURST beats, and muxes the winning producer's data onto a registered write strobe/data pair that drives the FIFO write side. Keeps its own occupancy count, fed by the read side's pop strobe, so the FIFO never overflows. Sits between the producers and the FIFO input control path.

## Interface

- N_REQ, 4, number of producers (2..8)
- DATA_W, 8, data width
- DEPTH, 16, FIFO capacity in words
- MAX_BURST, 4, maximum beats per grant (1..DEPTH)
- LVL_W, $clog2(DEPTH+1), occupancy width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-producer request; a high level means the producer has a word on its data slice
- req_data  in  N_REQ*DATA_W  producer data; slice i is [i*DATA_W +: DATA_W]
- rd_pop  in  1  one word left the FIFO this cycle (qualified read from the read side)
- gnt  out  N_REQ  registered one-hot grant, all-zero when idle
- write_en  out  1  registered FIFO write strobe
- wr_data  out  DATA_W  registered FIFO write data
- level  out  LVL_W  current occupancy count, 0..DEPTH
- full  out  1  asserted when level == DEPTH (combinational from level)

## Operation

- The FSM has two states: IDLE and BURST.
  - IDLE: if any req is high and level < DEPTH, select a winner with the round-robin picker, starting at last+1 modulo N_REQ. Load cur = winner, set gnt[cur] = 1, clear beat_cnt, and go to BURST. Otherwise stay in IDLE with gnt = 0.
  - BURST: a beat occurs when req[cur] && level < DEPTH.
    - On a beat: beat_cnt increments.
    - If beat_cnt == MAX_BURST-1 on that beat, go to IDLE, clear gnt, and set last = cur.
    - If req[cur] is low: go to IDLE, clear gnt, set last = cur. No beat occurs.
    - If req[cur] is high and level == DEPTH: stall. Stay in BURST, hold gnt, no beat.
- Producer handshake: a word on slice cur is consumed in each cycle where gnt[cur] && req[cur] && !full. The producer presents its next word on the following cycle.
- Write path: on a beat, register write_en = 1 and wr_data = req_data[cur]. In all other cycles write_en = 0 and wr_data holds its last value.
- Level update, applied every cycle:
  - beat only: +1
  - rd_pop only: -1
  - beat and rd_pop together: unchanged
  - rd_pop while level == 0: ignored, level stays 0
  - level never exceeds DEPTH.
- The beat decision uses the registered level, not the next value. At level == DEPTH a beat is refused even when rd_pop is high in the same cycle; it succeeds on the next cycle.
- Reset (async assert, sync deassert handled outside the block) gives: state = IDLE, gnt = 0, write_en = 0, wr_data = 0, level = 0, last = N_REQ-1 (so producer 0 wins first), beat_cnt = 0. Reset mid-burst drops the grant immediately. Any word accepted but not yet written is lost.

## Timing

- The first gnt goes high 1 cycle after req rises in IDLE.
- A beat is accepted in cycle t; write_en/wr_data are presented to the FIFO in cycle t+1.
- level changes at the clock edge that ends the beat cycle, one cycle before the FIFO sees the write. The count is therefore conservative.
- Back-to-back beats within a burst run at 1 word per cycle.
- After a burst ends there is exactly 1 idle cycle (gnt = 0) before the next grant.
- Fairness: a producer that keeps req high is served within (N_REQ-1) bursts.

## Structure

- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST)
  - the defaults for N_REQ, DATA_W, DEPTH, MAX_BURST
  - a function giving the level width from DEPTH.
- One sub-module, rr_pick: a combinational round-robin picker. Inputs are req and last; outputs are a one-hot winner and its index.
- Everything else (FSM, counters, data mux, write register) lives in the top-level module.

## Test plan

- Single producer, 6-word burst, MAX_BURST = 4: producer 0 holds req for 6 words with data 0x10..0x15.
  - Required: 4 write_en pulses (0x10..0x13), 1 cycle with gnt = 0, a re-grant, then 0x14 and 0x15.
  - Required: final level = 6.
- Round-robin: producers 0, 1 and 2 all hold req continuously.
  - Required grant order 0, 1, 2, 0, each grant 4 beats.
  - No producer is granted twice in a row.
- Full stall: producer 0 writes 16 words with no rd_pop.
  - Required: level reaches 16, full = 1, gnt[0] stays high, no 17th write_en.
  - Then one rd_pop: level drops to 15 and exactly one beat follows on the next cycle.
- Simultaneous beat and pop at level 8: level stays 8 and write_en pulses.
- rd_pop at level 0: level stays 0 and no write_en.
- Reset mid-burst: assert reset during the 2nd beat of a burst.
  - Required: gnt, write_en and level go to 0 asynchronously.
  - After release with req[1] and req[2] high, producer 1 is granted first and its gnt rises 1 cycle after reset is released.
